write_back_stage: RTL and testbench
===================================

# write_back_stage

Registered, parametrised write-back stage for the RV32 core. It selects the result source (memory, ALU, PC + increment, or immediate) and aligns and extends load data by access size. It waits on multi-cycle memory responses through a small state machine and drives the register-file write port one cycle later. It sits between the memory stage and the register file, replacing the purely combinational write-back mux.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- PC_INC, 4, value added to in_pc for source 10.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream result/instruction valid.
- in_ready  out  1  stage can accept; equals (state == IDLE).
- in_sel  in  2  source select: 00 mem, 01 alu, 10 pc+PC_INC, 11 imm.
- in_alu  in  XLEN  ALU result.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  immediate (LUI path).
- in_rd  in  5  destination register.
- in_rd_we  in  1  instruction writes rd.
- in_ld_funct3  in  3  load size/sign code.
- in_ld_addr_lo  in  2  load address bits [1:0].
- mem_rsp_valid  in  1  memory read data valid.
- mem_rsp_data  in  XLEN  aligned-word read data.
- rf_we  out  1  register-file write strobe, one-cycle pulse.
- rf_waddr  out  5  write address.
- rf_wdata  out  XLEN  write data.
- ld_err  out  1  one-cycle pulse: misaligned or illegal load.
- instret  out  64  retired-instruction count (only with WB_INSTRET_EN).

## Operation
- FSM states are IDLE and WAIT_MEM. Reset enters IDLE.
- Accept = in_valid && in_ready.
- IDLE, accept, in_sel != 00: the result is computed and registered. rf_we = in_rd_we && (in_rd != 0). The state stays IDLE.
- IDLE, accept, in_sel == 00, mem_rsp_valid low: latch rd, rd_we, funct3, and addr_lo, then go to WAIT_MEM.
- IDLE, accept, in_sel == 00, mem_rsp_valid high in the same cycle: complete directly as a load and stay IDLE.
- IDLE, no accept: mem_rsp_valid is ignored.
- WAIT_MEM: in_ready = 0. When mem_rsp_valid arrives, complete the load with the latched fields and return to IDLE.
- Load alignment: byte lane = addr_lo; half lane = addr_lo[1].
  - 000 LB: byte, sign-extended.
  - 100 LBU: byte, zero-extended.
  - 001 LH: half, sign-extended.
  - 101 LHU: half, zero-extended.
  - 010 LW: word [31:0], sign-extended to XLEN.
  - 110 LWU and 011 LD: legal only when XLEN=64. For 011, addr_lo must be 00 and the data is the full word.
- ld_err conditions:
  - half access with addr_lo[0]=1.
  - word access with addr_lo != 00.
  - any other funct3 value.
  - On ld_err, rf_we = 0 and rf_waddr/rf_wdata hold their previous values.
- Source 10: in_pc + PC_INC, modulo 2^XLEN.
- Writes to x0 are never strobed. They still count as retired.

## Timing
- Reset values: rf_we 0, rf_waddr 0, rf_wdata 0, ld_err 0, instret 0, state IDLE.
- Non-load latency: outputs valid on the cycle after accept.
- Load latency: outputs valid on the cycle after the mem_rsp_valid that completes the load.
- rf_we and ld_err are single-cycle pulses and are never asserted together.
- rf_waddr/rf_wdata hold their values when rf_we is 0.
- Back-to-back non-loads give one write per cycle.
- Throughput cost of a load: in_ready drops the cycle after the accept that enters WAIT_MEM. It returns on the cycle after mem_rsp_valid.
- rst high in WAIT_MEM discards the pending load. A later mem_rsp_valid seen in IDLE without accept has no effect.

## Configuration
- WB_INSTRET_EN defined: the instret port exists.
  - instret increments by 1 on every completed instruction, including rd=x0 and rd_we=0 cases, and excluding ld_err.
  - It updates in the same cycle as the rf_we slot and wraps from 2^64-1 to 0.
- WB_INSTRET_EN undefined: there is no instret port, no counter register, and the rest of the behaviour is identical.

## Test plan
- Reset, then ALU op: sel=01, alu=0x1234_5678, rd=5, rd_we=1 -> next cycle rf_we=1, waddr=5, wdata=0x1234_5678. instret=1 if enabled.
- JAL link: sel=10, pc=0xFFFF_FFFC, PC_INC=4 -> wdata=0x0000_0000 (wrap).
- LB with a 3-cycle memory: funct3=000, addr_lo=11, rsp=0x80AA_BBCC after 3 waits.
  - in_ready=0 throughout the wait.
  - Cycle after rsp: wdata=0xFFFF_FF80.
- Misaligned LH: funct3=001, addr_lo=01 with same-cycle rsp -> ld_err pulses, rf_we=0, instret unchanged.
- Reset during WAIT_MEM, then rsp without accept -> no rf_we, state IDLE, in_ready=1.
- rd=0 with rd_we=1, sel=11 -> rf_we=0, instret increments.

Source files
------------

// File: rtl/write_back_stage_if.sv
// Write-back stage port bundle: upstream result/instruction, memory response,
// register-file write port and load error pulse. The instret counter output is
// present only when WB_INSTRET_EN is defined.
interface write_back_stage_if #(
  parameter int XLEN = 32
) ();
  // upstream handshake and operands
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_sel;
  logic [XLEN-1:0] in_alu;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [4:0]      in_rd;
  logic            in_rd_we;
  logic [2:0]      in_ld_funct3;
  logic [1:0]      in_ld_addr_lo;
  // memory read response
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  // register-file write port and status
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            ld_err;
`ifdef WB_INSTRET_EN
  logic [63:0]     instret;
`endif

  // master: the memory stage / environment that feeds the write-back stage
  modport master (
    output in_valid, in_sel, in_alu, in_pc, in_imm, in_rd, in_rd_we,
    output in_ld_funct3, in_ld_addr_lo, mem_rsp_valid, mem_rsp_data,
    input  in_ready, rf_we, rf_waddr, rf_wdata, ld_err
`ifdef WB_INSTRET_EN
    , input instret
`endif
  );

  // slave: the write-back stage itself
  modport slave (
    input  in_valid, in_sel, in_alu, in_pc, in_imm, in_rd, in_rd_we,
    input  in_ld_funct3, in_ld_addr_lo, mem_rsp_valid, mem_rsp_data,
    output in_ready, rf_we, rf_waddr, rf_wdata, ld_err
`ifdef WB_INSTRET_EN
    , output instret
`endif
  );
endinterface

// File: rtl/write_back_stage.sv
// Registered RV32/RV64 write-back stage: result select, load align/extend, wait on memory.
// Latency: rf write one cycle after accept (non-load) or after the completing mem response (load).
// Backpressure: in_ready low while a load waits in WAIT_MEM. Optional macro: WB_INSTRET_EN adds instret.
module write_back_stage #(
  parameter int          XLEN   = 32,
  parameter int unsigned PC_INC = 4
) (
  input  logic              clk,
  input  logic              rst,
  write_back_stage_if.slave wb
);

  localparam logic [XLEN-1:0] LP_PC_INC = XLEN'(PC_INC);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  // fields of a load parked while waiting for its memory response
  logic [4:0]      r_pend_rd;
  logic            r_pend_rd_we;
  logic [2:0]      r_pend_f3;
  logic [1:0]      r_pend_lo;

  // registered write-port outputs
  logic            r_rf_we;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_ld_err;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_done;
  logic            w_is_load;
  logic            w_latch;
  logic [4:0]      w_rd;
  logic            w_rd_we;
  logic [2:0]      w_ld_f3;
  logic [1:0]      w_ld_lo;
  logic [XLEN:0]   w_ld_res;
  logic            w_ld_bad;
  logic [XLEN-1:0] w_ld_val;
  logic [XLEN-1:0] w_src_val;
  logic [XLEN-1:0] w_result;
  logic            w_err;
  logic            w_retire;
  logic            w_wr;

  // Align and extend load data. Returns {error, value}. Byte lane is addr_lo,
  // half lane is addr_lo[1]; word/doubleword forms need addr_lo == 00 and the
  // 64-bit-only forms are illegal on a 32-bit datapath.
  function automatic logic [XLEN:0] f_load(
    input logic [2:0]      f3,
    input logic [1:0]      lo,
    input logic [XLEN-1:0] d
  );
    logic [31:0]     w;
    logic [7:0]      b;
    logic [15:0]     h;
    logic            err;
    logic [XLEN-1:0] val;
    w   = d[31:0];
    b   = w[{lo, 3'b000} +: 8];
    h   = lo[1] ? w[31:16] : w[15:0];
    err = 1'b0;
    val = '0;
    case (f3)
      3'b000: val = XLEN'($signed(b));
      3'b100: val = XLEN'(b);
      3'b001: begin err = lo[0]; val = XLEN'($signed(h)); end
      3'b101: begin err = lo[0]; val = XLEN'(h); end
      3'b010: begin err = (lo != 2'b00); val = XLEN'($signed(w)); end
      3'b110: begin err = (XLEN != 64) || (lo != 2'b00); val = XLEN'(w); end
      3'b011: begin err = (XLEN != 64) || (lo != 2'b00); val = d; end
      default: err = 1'b1;
    endcase
    return {err, val};
  endfunction

  assign w_in_ready = (r_state == ST_IDLE);
  assign w_accept   = wb.in_valid && w_in_ready;

  // Next state and completion decode; a same-cycle memory response lets a
  // load finish straight from IDLE without visiting WAIT_MEM.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_is_load   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (wb.in_sel != 2'b00) begin
            w_done = 1'b1;
          end else if (wb.mem_rsp_valid) begin
            w_done    = 1'b1;
            w_is_load = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = ST_WAIT_MEM;
          end
        end
      end
      ST_WAIT_MEM: begin
        if (wb.mem_rsp_valid) begin
          w_done      = 1'b1;
          w_is_load   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // In WAIT_MEM the completing load uses its parked fields, otherwise the live inputs.
  always_comb begin
    if (r_state == ST_WAIT_MEM) begin
      w_rd    = r_pend_rd;
      w_rd_we = r_pend_rd_we;
      w_ld_f3 = r_pend_f3;
      w_ld_lo = r_pend_lo;
    end else begin
      w_rd    = wb.in_rd;
      w_rd_we = wb.in_rd_we;
      w_ld_f3 = wb.in_ld_funct3;
      w_ld_lo = wb.in_ld_addr_lo;
    end
  end

  assign w_ld_res = f_load(w_ld_f3, w_ld_lo, wb.mem_rsp_data);
  assign w_ld_bad = w_ld_res[XLEN];
  assign w_ld_val = w_ld_res[XLEN-1:0];

  // Non-load result source; the PC link value wraps naturally at XLEN bits.
  always_comb begin
    w_src_val = wb.in_alu;
    case (wb.in_sel)
      2'b10:   w_src_val = wb.in_pc + LP_PC_INC;
      2'b11:   w_src_val = wb.in_imm;
      default: w_src_val = wb.in_alu;
    endcase
  end

  assign w_result = w_is_load ? w_ld_val : w_src_val;
  assign w_err    = w_done && w_is_load && w_ld_bad;
  assign w_retire = w_done && !w_err;
  // x0 and rd_we=0 instructions retire but never strobe the register file
  assign w_wr     = w_retire && w_rd_we && (w_rd != 5'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Park the load fields when entering WAIT_MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_rd    <= 5'd0;
      r_pend_rd_we <= 1'b0;
      r_pend_f3    <= 3'd0;
      r_pend_lo    <= 2'd0;
    end else if (w_latch) begin
      r_pend_rd    <= wb.in_rd;
      r_pend_rd_we <= wb.in_rd_we;
      r_pend_f3    <= wb.in_ld_funct3;
      r_pend_lo    <= wb.in_ld_addr_lo;
    end
  end

  // Write-port outputs: strobes pulse for one cycle, address/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_ld_err   <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we  <= w_wr;
      r_ld_err <= w_err;
      if (w_wr) begin
        r_rf_waddr <= w_rd;
        r_rf_wdata <= w_result;
      end
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  // Retired-instruction counter, advancing in the same slot as the write strobe.
  always_ff @(posedge clk) begin
    if (rst)           r_instret <= 64'd0;
    else if (w_retire) r_instret <= r_instret + 64'd1;
  end

  assign wb.instret = r_instret;
`endif

  assign wb.in_ready = w_in_ready;
  assign wb.rf_we    = r_rf_we;
  assign wb.rf_waddr = r_rf_waddr;
  assign wb.rf_wdata = r_rf_wdata;
  assign wb.ld_err   = r_ld_err;

  // A write strobe and a load error can never be reported in the same cycle.
  a_we_err_excl: assert property (@(posedge clk) disable iff (rst) !(r_rf_we && r_ld_err));

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage (XLEN=32, PC_INC=4): vector table,
// hand-written multi-cycle sequences, then randomized traffic against a reference model.
module tb_write_back_stage;

  localparam int XLEN   = 32;
  localparam int PC_INC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  write_back_stage_if #(.XLEN(XLEN)) wbif ();

  write_back_stage #(.XLEN(XLEN), .PC_INC(PC_INC)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wbif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                        input logic we, input logic [2:0] f3, input logic [1:0] lo,
                        input logic rv, input logic [31:0] rdat);
    wbif.in_valid      = v;
    wbif.in_sel        = sel;
    wbif.in_alu        = alu;
    wbif.in_pc         = pc;
    wbif.in_imm        = imm;
    wbif.in_rd         = rd;
    wbif.in_rd_we      = we;
    wbif.in_ld_funct3  = f3;
    wbif.in_ld_addr_lo = lo;
    wbif.mem_rsp_valid = rv;
    wbif.mem_rsp_data  = rdat;
  endtask

  task automatic set_idle();
    set_in(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string name, input longint unsigned exp);
`ifdef WB_INSTRET_EN
    chk(name, wbif.instret, exp);
`else
    if (exp == 64'hFFFF_FFFF_FFFF_FFFF) $display("unused %s", name);
`endif
  endtask

  // ---------------- reference model ----------------
  // Load result from the architectural rules: shift the word down by the byte
  // offset, keep the access width, and sign-extend arithmetically.
  function automatic void ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d,
                                   output bit err, output logic [31:0] val);
    int nbytes;
    bit sgn;
    longint unsigned raw;
    err = 0; val = 32'h0; nbytes = 1; sgn = 0;
    case (f3)
      3'd0: begin nbytes = 1; sgn = 1; end
      3'd4: begin nbytes = 1; sgn = 0; end
      3'd1: begin nbytes = 2; sgn = 1; end
      3'd5: begin nbytes = 2; sgn = 0; end
      3'd2: begin nbytes = 4; sgn = 1; end
      default: err = 1;   // LWU / LD / 111 are illegal on a 32-bit core
    endcase
    if (!err && (int'(lo) % nbytes) != 0) err = 1;
    if (!err) begin
      raw = (64'(d) >> (8 * int'(lo))) & ((64'd1 << (8 * nbytes)) - 64'd1);
      if (sgn && raw[8*nbytes-1]) raw = raw - (64'd1 << (8 * nbytes));
      val = raw[31:0];
    end
  endfunction

  typedef struct {
    logic [4:0] rd;
    logic       we;
    logic [2:0] f3;
    logic [1:0] lo;
  } pend_t;

  pend_t           m_pend[$];
  bit              m_we, m_err;
  logic [4:0]      m_waddr;
  logic [31:0]     m_wdata;
  longint unsigned m_ret;

  task automatic m_reset();
    m_pend.delete();
    m_we = 0; m_err = 0; m_waddr = 5'd0; m_wdata = 32'h0; m_ret = 0;
  endtask

  task automatic m_finish(input logic [4:0] rd, input logic we, input bit err, input logic [31:0] val);
    if (err) begin
      m_err = 1;
    end else begin
      m_ret++;
      if (we && rd != 5'd0) begin
        m_we = 1; m_waddr = rd; m_wdata = val;
      end
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic m_edge(input logic r);
    bit          e;
    logic [31:0] v;
    pend_t       p;
    m_we = 0; m_err = 0;
    if (r) begin
      m_reset();
    end else if (m_pend.size() == 0) begin
      if (wbif.in_valid) begin
        if (wbif.in_sel == 2'b01) m_finish(wbif.in_rd, wbif.in_rd_we, 0, wbif.in_alu);
        else if (wbif.in_sel == 2'b10) m_finish(wbif.in_rd, wbif.in_rd_we, 0, wbif.in_pc + 32'(PC_INC));
        else if (wbif.in_sel == 2'b11) m_finish(wbif.in_rd, wbif.in_rd_we, 0, wbif.in_imm);
        else if (wbif.mem_rsp_valid) begin
          ref_load(wbif.in_ld_funct3, wbif.in_ld_addr_lo, wbif.mem_rsp_data, e, v);
          m_finish(wbif.in_rd, wbif.in_rd_we, e, v);
        end else begin
          p.rd = wbif.in_rd; p.we = wbif.in_rd_we; p.f3 = wbif.in_ld_funct3; p.lo = wbif.in_ld_addr_lo;
          m_pend.push_back(p);
        end
      end
    end else if (wbif.mem_rsp_valid) begin
      p = m_pend.pop_front();
      ref_load(p.f3, p.lo, wbif.mem_rsp_data, e, v);
      m_finish(p.rd, p.we, e, v);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic v; logic [1:0] sel; logic [31:0] alu; logic [31:0] pc; logic [31:0] imm;
    logic [4:0] rd; logic we; logic [2:0] f3; logic [1:0] lo; logic rv; logic [31:0] rdat;
    logic e_we; logic [4:0] e_addr; logic [31:0] e_dat; logic e_err; logic e_inc;
  } vec_t;

  vec_t tv[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned t_ret;
    string nm;

    //           v sel    alu           pc            imm           rd we f3     lo     rv rdat          e_we addr e_dat         err inc
    tv.push_back('{1, 2'b01, 32'h12345678, 32'h0,        32'h0,        5,  1, 3'b000, 2'b00, 0, 32'h0,        1, 5,  32'h12345678, 0, 1});
    tv.push_back('{1, 2'b10, 32'h0,        32'hFFFFFFFC, 32'h0,        1,  1, 3'b000, 2'b00, 0, 32'h0,        1, 1,  32'h00000000, 0, 1});
    tv.push_back('{1, 2'b11, 32'h0,        32'h0,        32'hABCDE000, 31, 1, 3'b000, 2'b00, 0, 32'h0,        1, 31, 32'hABCDE000, 0, 1});
    tv.push_back('{1, 2'b11, 32'h0,        32'h0,        32'h00005555, 0,  1, 3'b000, 2'b00, 0, 32'h0,        0, 31, 32'hABCDE000, 0, 1});
    tv.push_back('{1, 2'b01, 32'h00000001, 32'h0,        32'h0,        7,  0, 3'b000, 2'b00, 0, 32'h0,        0, 31, 32'hABCDE000, 0, 1});
    tv.push_back('{1, 2'b00, 32'h0,        32'h0,        32'h0,        3,  1, 3'b000, 2'b10, 1, 32'h12805634, 1, 3,  32'hFFFFFF80, 0, 1});
    tv.push_back('{1, 2'b00, 32'h0,        32'h0,        32'h0,        4,  1, 3'b100, 2'b01, 1, 32'h0000F100, 1, 4,  32'h000000F1, 0, 1});
    tv.push_back('{1, 2'b00, 32'h0,        32'h0,        32'h0,        6,  1, 3'b001, 2'b10, 1, 32'h80011234, 1, 6,  32'hFFFF8001, 0, 1});
    tv.push_back('{1, 2'b00, 32'h0,        32'h0,        32'h0,        8,  1, 3'b101, 2'b00, 1, 32'h12349ABC, 1, 8,  32'h00009ABC, 0, 1});
    tv.push_back('{1, 2'b00, 32'h0,        32'h0,        32'h0,        9,  1, 3'b010, 2'b00, 1, 32'hDEADBEEF, 1, 9,  32'hDEADBEEF, 0, 1});
    tv.push_back('{1, 2'b00, 32'h0,        32'h0,        32'h0,        10, 1, 3'b001, 2'b01, 1, 32'h11112222, 0, 9,  32'hDEADBEEF, 1, 0});
    tv.push_back('{1, 2'b00, 32'h0,        32'h0,        32'h0,        10, 1, 3'b010, 2'b10, 1, 32'h11112222, 0, 9,  32'hDEADBEEF, 1, 0});
    tv.push_back('{1, 2'b00, 32'h0,        32'h0,        32'h0,        10, 1, 3'b110, 2'b00, 1, 32'h11112222, 0, 9,  32'hDEADBEEF, 1, 0});
    tv.push_back('{1, 2'b00, 32'h0,        32'h0,        32'h0,        10, 1, 3'b011, 2'b00, 1, 32'h11112222, 0, 9,  32'hDEADBEEF, 1, 0});
    tv.push_back('{1, 2'b00, 32'h0,        32'h0,        32'h0,        10, 1, 3'b111, 2'b00, 1, 32'h11112222, 0, 9,  32'hDEADBEEF, 1, 0});
    tv.push_back('{0, 2'b00, 32'h0,        32'h0,        32'h0,        12, 1, 3'b010, 2'b00, 1, 32'h55555555, 0, 9,  32'hDEADBEEF, 0, 0});
    tv.push_back('{1, 2'b01, 32'hCAFEF00D, 32'h0,        32'h0,        2,  1, 3'b000, 2'b00, 0, 32'h0,        1, 2,  32'hCAFEF00D, 0, 1});
    tv.push_back('{1, 2'b00, 32'h0,        32'h0,        32'h0,        11, 1, 3'b000, 2'b00, 1, 32'h0000007F, 1, 11, 32'h0000007F, 0, 1});

    // ---- reset state ----
    set_idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_rf_we", wbif.rf_we, 1'b0);
    chk("reset_waddr", wbif.rf_waddr, 5'd0);
    chk("reset_wdata", wbif.rf_wdata, 32'h0);
    chk("reset_ld_err", wbif.ld_err, 1'b0);
    chk("reset_in_ready", wbif.in_ready, 1'b1);
    chk_ret("reset_instret", 0);

    // ---- table: single-cycle completions, back to back ----
    t_ret = 0;
    for (int i = 0; i < tv.size(); i++) begin
      set_in(tv[i].v, tv[i].sel, tv[i].alu, tv[i].pc, tv[i].imm, tv[i].rd, tv[i].we,
             tv[i].f3, tv[i].lo, tv[i].rv, tv[i].rdat);
      tick();
      if (tv[i].e_inc) t_ret++;
      nm = $sformatf("vec%0d", i);
      chk({nm, "_rf_we"}, wbif.rf_we, tv[i].e_we);
      chk({nm, "_waddr"}, wbif.rf_waddr, tv[i].e_addr);
      chk({nm, "_wdata"}, wbif.rf_wdata, tv[i].e_dat);
      chk({nm, "_ld_err"}, wbif.ld_err, tv[i].e_err);
      chk({nm, "_ready"}, wbif.in_ready, 1'b1);
      chk_ret({nm, "_instret"}, t_ret);
    end

    // ---- LB through a 3-cycle memory wait ----
    set_in(1, 2'b00, 32'h0, 32'h0, 32'h0, 5'd10, 1, 3'b000, 2'b11, 0, 32'h0);
    tick();
    chk("lbwait_accept_ready", wbif.in_ready, 1'b0);
    chk("lbwait_accept_we", wbif.rf_we, 1'b0);
    for (int w = 0; w < 3; w++) begin
      // a stalled non-load must not be taken while the load is outstanding
      set_in(1, 2'b01, 32'h11111111, 32'h0, 32'h0, 5'd20, 1, 3'b000, 2'b00, 0, 32'h0);
      tick();
      chk($sformatf("lbwait_w%0d_ready", w), wbif.in_ready, 1'b0);
      chk($sformatf("lbwait_w%0d_we", w), wbif.rf_we, 1'b0);
    end
    set_in(0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 0, 3'b000, 2'b00, 1, 32'h80AABBCC);
    tick();
    t_ret++;
    chk("lbwait_done_we", wbif.rf_we, 1'b1);
    chk("lbwait_done_waddr", wbif.rf_waddr, 5'd10);
    chk("lbwait_done_wdata", wbif.rf_wdata, 32'hFFFFFF80);
    chk("lbwait_done_err", wbif.ld_err, 1'b0);
    chk("lbwait_done_ready", wbif.in_ready, 1'b1);
    chk_ret("lbwait_done_instret", t_ret);
    set_idle();
    tick();
    chk("lbwait_pulse_we", wbif.rf_we, 1'b0);
    chk("lbwait_hold_wdata", wbif.rf_wdata, 32'hFFFFFF80);

    // ---- reset during WAIT_MEM, then a stray response ----
    set_in(1, 2'b00, 32'h0, 32'h0, 32'h0, 5'd13, 1, 3'b010, 2'b00, 0, 32'h0);
    tick();
    chk("rstwait_ready_low", wbif.in_ready, 1'b0);
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstwait_ready", wbif.in_ready, 1'b1);
    chk("rstwait_waddr", wbif.rf_waddr, 5'd0);
    chk_ret("rstwait_instret", 0);
    set_in(0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd13, 1, 3'b010, 2'b00, 1, 32'hFFFFFFFF);
    tick();
    chk("rstwait_rsp_we", wbif.rf_we, 1'b0);
    chk("rstwait_rsp_err", wbif.ld_err, 1'b0);
    chk("rstwait_rsp_ready", wbif.in_ready, 1'b1);
    chk("rstwait_rsp_wdata", wbif.rf_wdata, 32'h0);

    // ---- randomized traffic against the reference model ----
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [4:0] rd;
      logic       r;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      set_in(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
             ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom, $urandom, rd,
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0), $urandom);
      r = ($urandom_range(0, 199) == 0);
      rst = r;
      m_edge(r);
      tick();
      rst = 1'b0;
      chk($sformatf("rnd%0d_rf_we", c), wbif.rf_we, m_we);
      chk($sformatf("rnd%0d_ld_err", c), wbif.ld_err, m_err);
      chk($sformatf("rnd%0d_waddr", c), wbif.rf_waddr, m_waddr);
      chk($sformatf("rnd%0d_wdata", c), wbif.rf_wdata, m_wdata);
      chk($sformatf("rnd%0d_ready", c), wbif.in_ready, (m_pend.size() == 0));
      chk_ret($sformatf("rnd%0d_instret", c), m_ret);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
